// File: rtl/modn_cascade_counter_pkg.sv
// rtl/modn_cascade_counter_pkg.sv - shared defaults, stage operation codes and modulus helper
package modn_cascade_counter_pkg;

  // Default configuration: two 4-bit stages, mod-10 low and mod-6 high (00..59).
  localparam int               DEF_STAGES  = 2;
  localparam int               DEF_W       = 4;
  localparam logic [7:0]       DEF_MOD_VEC = 8'h6A;

  // What a single stage does on the next rising edge, already priority-resolved.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLR   = 2'd3
  } stage_op_e;

  // A modulus field of 0 stands for the full 2**w range of the stage.
  function automatic int stage_mod(input logic [31:0] field, input int w);
    if (field == 32'd0) begin
      return 1 << w;
    end
    return int'(field);
  endfunction

endpackage

// File: rtl/modn_cascade_counter_digit.sv
// rtl/modn_cascade_counter_digit.sv - one modulo-MOD up/down stage with load range check
module modn_cascade_counter_digit
  import modn_cascade_counter_pkg::*;
#(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cin,
  input  logic         i_up,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_co,
  output logic         o_ld_bad
);

  // Terminal value of the stage; MOD = 2**W gives all-ones.
  localparam logic [W-1:0] TOP     = W'(MOD - 1);
  localparam logic [W:0]   MOD_EXT = (W+1)'(MOD);

  logic [W-1:0] r_q;
  logic [W-1:0] w_next;
  logic [W-1:0] w_ld_val;
  logic         w_d_bad;
  stage_op_e    w_op;

  assign w_d_bad  = ({1'b0, i_d} >= MOD_EXT);
  assign w_ld_val = w_d_bad ? '0 : i_d;
  assign o_ld_bad = i_ld & w_d_bad;
  assign o_q      = r_q;

  // Carry/borrow out depends on the live direction so it re-evaluates between edges.
  assign o_co = i_cin & (i_up ? (r_q == TOP) : (r_q == '0));

  // Resolve CLR > LD > count > hold for this stage.
  always_comb begin
    w_op = OP_HOLD;
    if (i_clr) begin
      w_op = OP_CLR;
    end else if (i_ld) begin
      w_op = OP_LOAD;
    end else if (i_cin) begin
      w_op = OP_COUNT;
    end
  end

  // Next count value; an out-of-range value (upset) is pulled back to 0 in either direction.
  always_comb begin
    w_next = r_q;
    if (i_up) begin
      if (r_q >= TOP) begin
        w_next = '0;
      end else begin
        w_next = r_q + W'(1);
      end
    end else begin
      if (r_q == '0) begin
        w_next = TOP;
      end else if (r_q > TOP) begin
        w_next = '0;
      end else begin
        w_next = r_q - W'(1);
      end
    end
  end

  // Stage register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      case (w_op)
        OP_CLR:   r_q <= '0;
        OP_LOAD:  r_q <= w_ld_val;
        OP_COUNT: r_q <= w_next;
        default:  r_q <= r_q;
      endcase
    end
  end

endmodule

// File: rtl/modn_cascade_counter.sv
// rtl/modn_cascade_counter.sv - cascaded multi-stage modulo up/down counter with load error flag
module modn_cascade_counter
  import modn_cascade_counter_pkg::*;
#(
  parameter int                  STAGES  = DEF_STAGES,
  parameter int                  W       = DEF_W,
  parameter logic [STAGES*W-1:0] MOD_VEC = DEF_MOD_VEC
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic                i_ld,
  input  logic                i_up,
  input  logic [STAGES*W-1:0] i_d,
  output logic [STAGES*W-1:0] o_q,
  output logic [STAGES-1:0]   o_co,
  output logic                o_tc,
  output logic                o_ld_err
);

  // w_carry[k] is the carry-in of stage k; w_carry[STAGES] is the terminal count.
  logic [STAGES:0]   w_carry;
  logic [STAGES-1:0] w_ld_bad;
  logic              r_ld_err;

  assign w_carry[0] = i_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int MOD_K = stage_mod(32'(MOD_VEC[k*W +: W]), W);

    modn_cascade_counter_digit #(
      .W   (W),
      .MOD (MOD_K)
    ) u_digit (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_cin    (w_carry[k]),
      .i_up     (i_up),
      .i_clr    (i_clr),
      .i_ld     (i_ld),
      .i_d      (i_d[k*W +: W]),
      .o_q      (o_q[k*W +: W]),
      .o_co     (w_carry[k+1]),
      .o_ld_bad (w_ld_bad[k])
    );
  end

  assign o_co     = w_carry[STAGES:1];
  assign o_tc     = w_carry[STAGES];
  assign o_ld_err = r_ld_err;

  // One-cycle flag for a load that had to replace at least one digit; CLR overrides the load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ld_err <= 1'b0;
    end else begin
      r_ld_err <= ~i_clr & i_ld & (|w_ld_bad);
    end
  end

endmodule
